ysyx_24070017_rf_wbq: RTL and testbench

Write-back queue and read-port front end for the flat general-purpose register file. Buffers retiring register writes from the execute stage behind a valid/ready handshake. Drains one entry per committed cycle into the register file's one-hot write-enable / flat write-data port. Serves two combinational read ports by slicing the register file's flat read bus, with optional forwarding from pending queue entries.

---
 rtl/ysyx_24070017_rf_wbq_pkg.sv | 23 ++
 rtl/ysyx_24070017_rf_rdport.sv | 37 +++
 rtl/ysyx_24070017_rf_wbq.sv | 117 +++++++++++
 tb/tb_ysyx_24070017_rf_wbq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24070017_rf_wbq_pkg.sv
// Shared register-file defines and package for the write-back queue slice.
// Optional bypass feature: define YSYX_24070017_RF_BYPASS_EN.
`ifndef YSYX_24070017_DEFINES_SV
`define YSYX_24070017_DEFINES_SV
`define ysyx_24070017_WORD_LENGTH 32
`define ysyx_24070017_RF_REG_NUM 32
`define ysyx_24070017_RF_ADDR_W 5
`define ysyx_24070017_WORD_TYPE(idx) [(idx)*`ysyx_24070017_WORD_LENGTH +: `ysyx_24070017_WORD_LENGTH]
`endif

package ysyx_24070017_rf_wbq_pkg;
  localparam int WORD_LENGTH = `ysyx_24070017_WORD_LENGTH;
  localparam int RF_REG_NUM  = `ysyx_24070017_RF_REG_NUM;
  localparam int RF_ADDR_W   = `ysyx_24070017_RF_ADDR_W;

  // Encoded as {push, pop} so the queue op can be cast straight from the two strobes.
  typedef enum logic [1:0] {
    Q_IDLE = 2'b00,
    Q_POP  = 2'b01,
    Q_PUSH = 2'b10,
    Q_BOTH = 2'b11
  } q_op_e;
endpackage

// File: rtl/ysyx_24070017_rf_rdport.sv
// One register-file read port: flat-bus slice, x0 zeroing, pending match and
// youngest-first forwarding (only when YSYX_24070017_RF_BYPASS_EN is defined).
module ysyx_24070017_rf_rdport #(
  parameter int W     = 32,
  parameter int N     = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 2
) (
  input  logic [AW-1:0]       addr,
  input  logic [N*W-1:0]      rf_rdata,
  input  logic [DEPTH-1:0]    ent_vld,
  input  logic [DEPTH*AW-1:0] ent_rd,
  input  logic [DEPTH*W-1:0]  ent_data,
  output logic [W-1:0]        data,
  output logic                pending
);

  // Entries arrive ordered oldest (k=0) to youngest, so later matches win.
  always_comb begin
    pending = 1'b0;
    data    = (addr == '0) ? '0 : rf_rdata[int'(addr)*W +: W];
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_vld[k] && (addr != '0) && (ent_rd[k*AW +: AW] == addr)) begin
        pending = 1'b1;
`ifdef YSYX_24070017_RF_BYPASS_EN
        data = ent_data[k*W +: W];
`endif
      end
    end
  end

`ifndef YSYX_24070017_RF_BYPASS_EN
  logic unused_ent_data;
  assign unused_ent_data = ^ent_data;
`endif

endmodule

// File: rtl/ysyx_24070017_rf_wbq.sv
// Write-back queue in front of the flat register file, with two read ports.
// Define YSYX_24070017_RF_BYPASS_EN to forward pending queue data to the read ports.
module ysyx_24070017_rf_wbq
  import ysyx_24070017_rf_wbq_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = WORD_LENGTH,
  parameter int N     = RF_REG_NUM,
  parameter int AW    = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [AW-1:0]         wb_rd,
  input  logic [W-1:0]          wb_data,
  input  logic                  commit_en,
  input  logic                  flush,
  output logic [N-1:0]          rf_we,
  output logic [N*W-1:0]        rf_wdata,
  input  logic [N*W-1:0]        rf_rdata,
  input  logic [AW-1:0]         rs1_addr,
  input  logic [AW-1:0]         rs2_addr,
  output logic [W-1:0]          rs1_data,
  output logic [W-1:0]          rs2_data,
  output logic                  rs1_pending,
  output logic                  rs2_pending,
  output logic [$clog2(DEPTH):0] pend_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0] q_rd   [DEPTH];
  logic [W-1:0]  q_data [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic  pop, push;
  q_op_e q_op;

  assign wb_ready = !rst && !flush &&
                    ((count < DEPTH_C) || ((count != '0) && commit_en));
  assign pop      = commit_en && (count != '0) && !flush && !rst;
  // x0 writes complete the handshake but never occupy a slot.
  assign push     = wb_valid && wb_ready && (wb_rd != '0);
  assign q_op     = q_op_e'({push, pop});
  assign pend_cnt = count;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case (q_op)
        Q_PUSH:  count <= count + CW'(1);
        Q_POP:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[tail]   <= wb_rd;
      q_data[tail] <= wb_data;
    end
  end

  always_comb begin
    rf_we    = '0;
    rf_wdata = '0;
    if (pop) begin
      rf_we[q_rd[head]] = 1'b1;
      rf_we[0]          = 1'b0;
      rf_wdata          = {N{q_data[head]}};
    end
  end

  // Present the queue to the read ports in age order, oldest first.
  logic [DEPTH-1:0]    ent_vld;
  logic [DEPTH*AW-1:0] ent_rd;
  logic [DEPTH*W-1:0]  ent_data;

  for (genvar k = 0; k < DEPTH; k++) begin : g_ord
    logic [PW-1:0] idx;
    assign idx                  = head + PW'(k);
    assign ent_vld[k]           = CW'(k) < count;
    assign ent_rd[k*AW +: AW]   = q_rd[idx];
    assign ent_data[k*W +: W]   = q_data[idx];
  end

  ysyx_24070017_rf_rdport #(.W(W), .N(N), .AW(AW), .DEPTH(DEPTH)) u_rs1 (
    .addr     (rs1_addr),
    .rf_rdata (rf_rdata),
    .ent_vld  (ent_vld),
    .ent_rd   (ent_rd),
    .ent_data (ent_data),
    .data     (rs1_data),
    .pending  (rs1_pending)
  );

  ysyx_24070017_rf_rdport #(.W(W), .N(N), .AW(AW), .DEPTH(DEPTH)) u_rs2 (
    .addr     (rs2_addr),
    .rf_rdata (rf_rdata),
    .ent_vld  (ent_vld),
    .ent_rd   (ent_rd),
    .ent_data (ent_data),
    .data     (rs2_data),
    .pending  (rs2_pending)
  );

endmodule

// File: tb/tb_ysyx_24070017_rf_wbq.sv
// Self-checking bench for ysyx_24070017_rf_wbq: directed steps then random traffic
// against a queue-based reference model; the bench also plays the register file.
module tb_ysyx_24070017_rf_wbq;
  localparam int DEPTH = 2;
  localparam int W     = 32;
  localparam int N     = 32;
  localparam int AW    = 5;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int FW    = N * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, wb_valid, wb_ready, commit_en, flush;
  logic [AW-1:0] wb_rd, rs1_addr, rs2_addr;
  logic [W-1:0]  wb_data, rs1_data, rs2_data;
  logic [N-1:0]  rf_we;
  logic [FW-1:0] rf_wdata, rf_rdata;
  logic          rs1_pending, rs2_pending;
  logic [CW-1:0] pend_cnt;

  ysyx_24070017_rf_wbq #(.DEPTH(DEPTH), .W(W), .N(N), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .commit_en(commit_en), .flush(flush),
    .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .pend_cnt(pend_cnt)
  );

  logic [W-1:0] rf_mem [N];
  always_comb begin
    rf_rdata = '0;
    for (int i = 0; i < N; i++) rf_rdata[i*W +: W] = rf_mem[i];
  end

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [W-1:0]  data;
  } ent_t;
  ent_t mq[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  function automatic logic m_ready();
    return !rst && !flush && ((mq.size() < DEPTH) || ((mq.size() != 0) && commit_en));
  endfunction

  function automatic logic m_pop();
    return !rst && !flush && commit_en && (mq.size() != 0);
  endfunction

  function automatic logic m_pend(input logic [AW-1:0] a);
    logic p = 1'b0;
    foreach (mq[i]) if (a != 0 && mq[i].rd == a) p = 1'b1;
    return p;
  endfunction

  function automatic logic [W-1:0] m_read(input logic [AW-1:0] a);
    logic [W-1:0] v;
    if (a == 0) return '0;
    v = rf_mem[a];
`ifdef YSYX_24070017_RF_BYPASS_EN
    foreach (mq[i]) if (mq[i].rd == a) v = mq[i].data;
`endif
    return v;
  endfunction

  task automatic check_outputs();
    logic [N-1:0]  e_we;
    logic [FW-1:0] e_wd;
    e_we = '0;
    e_wd = '0;
    if (m_pop()) begin
      e_we[mq[0].rd] = 1'b1;
      e_wd = {N{mq[0].data}};
    end
    chk("wb_ready",    FW'(wb_ready),    FW'(m_ready()));
    chk("rf_we",       FW'(rf_we),       FW'(e_we));
    chk("rf_wdata",    rf_wdata,         e_wd);
    chk("pend_cnt",    FW'(pend_cnt),    FW'(mq.size()));
    chk("rs1_data",    FW'(rs1_data),    FW'(m_read(rs1_addr)));
    chk("rs2_data",    FW'(rs2_data),    FW'(m_read(rs2_addr)));
    chk("rs1_pending", FW'(rs1_pending), FW'(m_pend(rs1_addr)));
    chk("rs2_pending", FW'(rs2_pending), FW'(m_pend(rs2_addr)));
  endtask

  task automatic mid();
    #4;
    check_outputs();
  endtask

  task automatic edge_();
    logic p, a;
    @(posedge clk);
    p = m_pop();
    a = wb_valid && m_ready();
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (p) begin
        rf_mem[mq[0].rd] = mq[0].data;
        void'(mq.pop_front());
      end
      if (a && wb_rd != 0) mq.push_back('{rd: wb_rd, data: wb_data});
    end
    #1;
  endtask

  task automatic tick();
    mid();
    edge_();
  endtask

  task automatic put(input logic [AW-1:0] rd, input logic [W-1:0] d);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = d;
  endtask

  logic [W-1:0] old7;

  initial begin
    for (int i = 0; i < N; i++) rf_mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
    rf_mem[0] = 32'hDEAD_BEEF;
    rst = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    commit_en = 1'b0; flush = 1'b0; rs1_addr = '0; rs2_addr = '0;
    edge_();
    tick();
    mid();
    chk("ready_in_rst", FW'(wb_ready), FW'(0));
    edge_();
    rst = 1'b0;
    mid();
    chk("ready_after_rst", FW'(wb_ready), FW'(1));
    chk("pend_after_rst", FW'(pend_cnt), FW'(0));
    edge_();

    // single write x5 = 0x1234 with commit enabled
    put(5, 32'h1234); commit_en = 1'b1; rs1_addr = 5;
    tick();
    wb_valid = 1'b0;
    mid();
    chk("x5_we_n1", FW'(rf_we), FW'(32'h20));
    chk("x5_wdata_n1", FW'(rf_wdata[W +: W]), FW'(32'h1234));
    edge_();
    mid();
    chk("x5_read_n2", FW'(rs1_data), FW'(32'h1234));
    edge_();

    // x0 write is handshaken but discarded
    put(0, 32'hFFFF_FFFF); rs1_addr = 0;
    mid();
    chk("x0_ready", FW'(wb_ready), FW'(1));
    edge_();
    wb_valid = 1'b0;
    mid();
    chk("x0_pend", FW'(pend_cnt), FW'(0));
    chk("x0_we", FW'(rf_we), FW'(0));
    chk("x0_read", FW'(rs1_data), FW'(0));
    edge_();

    // fill to DEPTH with commit held, then pop and accept together
    commit_en = 1'b0;
    put(1, 32'h11); tick();
    put(2, 32'h22); tick();
    put(3, 32'h33);
    mid();
    chk("full_ready", FW'(wb_ready), FW'(0));
    chk("full_cnt", FW'(pend_cnt), FW'(2));
    edge_();
    commit_en = 1'b1;
    mid();
    chk("full_pop_ready", FW'(wb_ready), FW'(1));
    chk("full_pop_we", FW'(rf_we), FW'(32'h2));
    edge_();
    wb_valid = 1'b0;
    mid();
    chk("drain_x2", FW'(rf_we), FW'(32'h4));
    chk("drain_cnt", FW'(pend_cnt), FW'(2));
    edge_();
    mid();
    chk("drain_x3", FW'(rf_we), FW'(32'h8));
    edge_();
    tick();

    // two pending writes to x7
    commit_en = 1'b0; rs2_addr = 7; old7 = rf_mem[7];
    put(7, 32'h1); tick();
    put(7, 32'h2); tick();
    wb_valid = 1'b0;
    mid();
    chk("x7_pending", FW'(rs2_pending), FW'(1));
`ifdef YSYX_24070017_RF_BYPASS_EN
    chk("x7_bypass", FW'(rs2_data), FW'(32'h2));
`else
    chk("x7_nobypass", FW'(rs2_data), FW'(old7));
`endif
    edge_();

    // flush with a same-cycle request
    flush = 1'b1; commit_en = 1'b1; put(9, 32'h99);
    mid();
    chk("flush_ready", FW'(wb_ready), FW'(0));
    chk("flush_we", FW'(rf_we), FW'(0));
    edge_();
    flush = 1'b0; wb_valid = 1'b0;
    mid();
    chk("flush_cnt", FW'(pend_cnt), FW'(0));
    chk("flush_pend", FW'(rs2_pending), FW'(0));
    edge_();

    // reset mid-operation
    commit_en = 1'b0;
    put(10, 32'hA0); tick();
    put(11, 32'hB0); tick();
    wb_valid = 1'b0; rst = 1'b1; commit_en = 1'b1;
    mid();
    chk("rst_we", FW'(rf_we), FW'(0));
    chk("rst_wdata", rf_wdata, '0);
    edge_();
    rst = 1'b0; commit_en = 1'b0;
    mid();
    chk("post_rst_cnt", FW'(pend_cnt), FW'(0));
    chk("post_rst_ready", FW'(wb_ready), FW'(1));
    chk("post_rst_we", FW'(rf_we), FW'(0));
    edge_();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      wb_valid  = ($urandom_range(0, 99) < 60);
      wb_rd     = AW'($urandom_range(0, 15));
      wb_data   = $urandom;
      commit_en = ($urandom_range(0, 99) < 65);
      flush     = ($urandom_range(0, 99) < 4);
      rst       = ($urandom_range(0, 99) < 2);
      rs1_addr  = AW'($urandom_range(0, 15));
      rs2_addr  = AW'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0; flush = 1'b0; wb_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
